// File: rtl/uart_pkg.sv
// Shared defaults and helpers for the UART baud-rate generator.
package uart_pkg;

  // Default phase accumulator width in bits.
  localparam int unsigned N_DEF     = 16;
  // Default receive ticks per transmit tick (oversampling ratio).
  localparam int unsigned OSR_DEF   = 16;
  // Default increment loaded at reset.
  localparam int unsigned K_RST_DEF = 1;

  // Increment selection: INC = round(baud * OSR * 2^N / f_clk).
  // Example: 115200 baud, OSR 16, N 16, f_clk 50 MHz -> INC = 2416.
  // The resulting receive tick rate is f_clk * INC / 2^N.

  // Ceiling log2, minimum 1, used to size the oversample index.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) begin
        r = 32'(i + 1);
      end
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tick_div.sv
// Divides the receive tick stream by OSR to form the bit-rate tick and phase.
module uart_tick_div
  import uart_pkg::*;
#(
  parameter  int unsigned OSR = OSR_DEF,
  localparam int unsigned PW  = clog2(OSR)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          tick_i,
  output logic          tick_tx_o,
  output logic [PW-1:0] phase_o
);

  localparam logic [PW-1:0] LAST = PW'(OSR - 1);

  logic [PW-1:0] cnt_q, cnt_d;
  logic          tick_tx_q, tick_tx_d;

  // Advance the oversample index on each receive tick; flag the wrap.
  always_comb begin
    cnt_d     = cnt_q;
    tick_tx_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == LAST) begin
        cnt_d     = '0;
        tick_tx_d = 1'b1;
      end else begin
        cnt_d = cnt_q + PW'(1);
      end
    end
  end

  // Divider state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      tick_tx_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tick_tx_q <= tick_tx_d;
    end
  end

  assign tick_tx_o = tick_tx_q;
  assign phase_o   = cnt_q;

endmodule

// File: rtl/uart_baud_gen.sv
// Fractional (phase-accumulator) UART baud generator producing oversample
// and bit-rate clock-enable strobes.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter  int unsigned N     = N_DEF,
  parameter  int unsigned OSR   = OSR_DEF,
  parameter  int unsigned K_RST = K_RST_DEF,
  localparam int unsigned PW    = clog2(OSR)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          inc_wr_i,
  input  logic [N-1:0]  inc_in_i,
  input  logic          sync_i,
  output logic          tick_rx_o,
  output logic          tick_tx_o,
  output logic [PW-1:0] phase_o
);

  // Half a sample period: realigning here centres the first sample.
  localparam logic [N-1:0] HALF = {1'b1, {(N-1){1'b0}}};

  logic [N-1:0] inc_q, inc_d;
  logic [N-1:0] acc_q, acc_d;
  logic         tick_rx_q, tick_rx_d;
  logic [N:0]   sum;
  logic         clr;

  assign sum = {1'b0, acc_q} + {1'b0, inc_q};
  assign clr = inc_wr_i | sync_i;

  // Next increment/accumulator; a carry out of the top bit is a receive tick.
  always_comb begin
    inc_d     = inc_q;
    acc_d     = acc_q;
    tick_rx_d = 1'b0;
    if (inc_wr_i) begin
      inc_d = inc_in_i;
    end
    if (sync_i) begin
      acc_d = HALF;
    end else if (inc_wr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d     = sum[N-1:0];
      tick_rx_d = sum[N];
    end
  end

  // Accumulator state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inc_q     <= N'(K_RST);
      acc_q     <= '0;
      tick_rx_q <= 1'b0;
    end else begin
      inc_q     <= inc_d;
      acc_q     <= acc_d;
      tick_rx_q <= tick_rx_d;
    end
  end

  // Divider advances on the same edge the receive tick is registered,
  // so the bit tick always coincides with a receive tick.
  uart_tick_div #(
    .OSR(OSR)
  ) u_div (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (clr),
    .tick_i   (tick_rx_d),
    .tick_tx_o(tick_tx_o),
    .phase_o  (phase_o)
  );

  assign tick_rx_o = tick_rx_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: total-phase reference model plus directed scenarios.
module tb_uart_baud_gen;
  import uart_pkg::*;

  localparam int unsigned N     = 8;
  localparam int unsigned OSR_A = 16;
  localparam int unsigned OSR_B = 3;
  localparam int unsigned K_RST = 16;
  localparam int unsigned PWA   = clog2(OSR_A);
  localparam int unsigned PWB   = clog2(OSR_B);

  logic           clk = 1'b0;
  logic           rst, en, inc_wr, sync;
  logic [N-1:0]   inc_in;
  logic           rx_a, tx_a, rx_b, tx_b;
  logic [PWA-1:0] ph_a;
  logic [PWB-1:0] ph_b;

  uart_baud_gen #(.N(N), .OSR(OSR_A), .K_RST(K_RST)) dut_a (
    .clk_i(clk), .rst_i(rst), .en_i(en), .inc_wr_i(inc_wr), .inc_in_i(inc_in),
    .sync_i(sync), .tick_rx_o(rx_a), .tick_tx_o(tx_a), .phase_o(ph_a)
  );

  uart_baud_gen #(.N(N), .OSR(OSR_B), .K_RST(K_RST)) dut_b (
    .clk_i(clk), .rst_i(rst), .en_i(en), .inc_wr_i(inc_wr), .inc_in_i(inc_in),
    .sync_i(sync), .tick_rx_o(rx_b), .tick_tx_o(tx_b), .phase_o(ph_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: total phase T accumulated since the last realignment; the number
  // of receive ticks so far is floor(T / 2^N), phase is that count mod OSR.
  longint m_t   = 0;
  longint m_inc = K_RST;
  bit     e_rx  = 0, e_tx_a = 0, e_tx_b = 0;
  longint e_ph_a = 0, e_ph_b = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_update();
    longint c0, c1;
    if (rst) begin
      m_inc = K_RST; m_t = 0;
      e_rx = 0; e_tx_a = 0; e_tx_b = 0; e_ph_a = 0; e_ph_b = 0;
    end else if (inc_wr || sync) begin
      if (inc_wr) m_inc = longint'(inc_in);
      m_t = sync ? 128 : 0;
      e_rx = 0; e_tx_a = 0; e_tx_b = 0; e_ph_a = 0; e_ph_b = 0;
    end else if (en) begin
      c0 = m_t / 256;
      m_t = m_t + m_inc;
      c1 = m_t / 256;
      e_rx   = (c1 > c0);
      e_tx_a = e_rx && (c1 % OSR_A == 0);
      e_tx_b = e_rx && (c1 % OSR_B == 0);
      e_ph_a = c1 % OSR_A;
      e_ph_b = c1 % OSR_B;
    end else begin
      e_rx = 0; e_tx_a = 0; e_tx_b = 0;
    end
  endtask

  task automatic compare();
    chk("rx_a", rx_a, e_rx);
    chk("tx_a", tx_a, e_tx_a);
    chk("phase_a", ph_a, e_ph_a);
    chk("rx_b", rx_b, e_rx);
    chk("tx_b", tx_b, e_tx_b);
    chk("phase_b", ph_b, e_ph_b);
    chk("tx_without_rx_a", tx_a & ~rx_a, 0);
  endtask

  // One clock: model follows the sampled inputs, outputs checked mid-cycle.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  initial begin
    int first, last, cnt_rx, cnt_tx, cnt_txb, gap, gmin, gmax, changed, found;
    int unsigned p;

    rst = 1; en = 0; inc_wr = 0; sync = 0; inc_in = '0;
    step();
    chk("reset_rx", rx_a, 0);
    chk("reset_tx", tx_a, 0);
    chk("reset_phase", ph_a, 0);

    // Reset rate (K_RST = 16): receive tick every 16, bit tick every 256.
    rst = 0; en = 1;
    first = 0; last = 0; cnt_rx = 0; cnt_tx = 0; cnt_txb = 0;
    for (int i = 1; i <= 256; i++) begin
      step();
      if (rx_a) begin cnt_rx++; if (first == 0) first = i; end
      if (tx_a) begin cnt_tx++; last = i; end
      if (tx_b) cnt_txb++;
    end
    chk("first_rx_at16", first, 16);
    chk("rx_count_256", cnt_rx, 16);
    chk("tx_count_256", cnt_tx, 1);
    chk("tx_at256", last, 256);
    chk("phase_after_tx", ph_a, 0);
    chk("osr3_tx_count", cnt_txb, 5);

    // Rate change to 32: quiet cycle, then tick every 8.
    inc_wr = 1; inc_in = 8'd32;
    step();
    inc_wr = 0;
    chk("incwr_rx", rx_a, 0);
    chk("incwr_phase", ph_a, 0);
    first = 0; cnt_rx = 0;
    for (int i = 1; i <= 48; i++) begin
      step();
      if (rx_a) begin cnt_rx++; if (first == 0) first = i; end
    end
    chk("inc32_first_rx", first, 8);
    chk("inc32_rx_count", cnt_rx, 6);

    // Back to 16, then realign at phase 7.
    inc_wr = 1; inc_in = 8'd16;
    step();
    inc_wr = 0;
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      step();
      if (ph_a == 7) found = 1;
    end
    chk("reached_phase7", found, 1);
    sync = 1;
    step();
    sync = 0;
    chk("sync_phase", ph_a, 0);
    chk("sync_rx", rx_a, 0);
    first = 0; cnt_rx = 0; found = 0; last = 0;
    for (int i = 1; i <= 400 && found == 0; i++) begin
      step();
      if (rx_a) begin cnt_rx++; if (first == 0) first = i; end
      if (tx_a) begin found = 1; last = cnt_rx; end
    end
    chk("sync_first_rx", first, 8);
    chk("sync_tx_seen", found, 1);
    chk("sync_rx_per_tx", last, 16);

    // Pause mid-bit for 50 cycles, then resume.
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      step();
      if (ph_a == 5) found = 1;
    end
    chk("reached_phase5", found, 1);
    en = 0;
    p = 32'(ph_a);
    cnt_rx = 0; changed = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (rx_a || tx_a || rx_b || tx_b) cnt_rx++;
      if (32'(ph_a) != p) changed++;
    end
    chk("paused_strobes", cnt_rx, 0);
    chk("paused_phase_moves", changed, 0);
    en = 1;
    first = 0;
    for (int i = 1; i <= 40 && first == 0; i++) begin
      step();
      if (rx_a) first = i;
    end
    chk("resume_gap", first, 16);

    // Reset wins over write and sync.
    rst = 1; inc_wr = 1; inc_in = 8'd77; sync = 1;
    step();
    chk("rst_prio_rx", rx_a, 0);
    chk("rst_prio_tx", tx_a, 0);
    chk("rst_prio_phase_a", ph_a, 0);
    chk("rst_prio_phase_b", ph_b, 0);
    rst = 0; inc_wr = 0; sync = 0;
    first = 0; cnt_rx = 0; cnt_txb = 0;
    for (int i = 1; i <= 144; i++) begin
      step();
      if (rx_a) begin cnt_rx++; if (first == 0) first = i; end
      if (tx_b) cnt_txb++;
    end
    chk("rst_rate_first_rx", first, 16);
    chk("rst_rate_rx_count", cnt_rx, 9);
    chk("osr3_tx_every3", cnt_txb, 3);

    // INC = 0 stops the generator.
    inc_wr = 1; inc_in = 8'd0;
    step();
    inc_wr = 0;
    cnt_rx = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (rx_a) cnt_rx++;
    end
    chk("inc0_no_ticks", cnt_rx, 0);

    // INC = 3 over 1280 cycles: 15 ticks, gaps of 85 or 86.
    inc_wr = 1; inc_in = 8'd3;
    step();
    inc_wr = 0;
    cnt_rx = 0; last = 0; gmin = 100000; gmax = 0;
    for (int i = 1; i <= 1280; i++) begin
      step();
      if (rx_a) begin
        if (last != 0) begin
          gap = i - last;
          if (gap < gmin) gmin = gap;
          if (gap > gmax) gmax = gap;
        end
        last = i;
        cnt_rx++;
      end
    end
    chk("inc3_rx_count", cnt_rx, 15);
    chk("inc3_gap_min", gmin, 85);
    chk("inc3_gap_max", gmax, 86);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst    = ($urandom_range(0, 499) == 0);
      inc_wr = ($urandom_range(0, 199) == 0);
      sync   = ($urandom_range(0, 149) == 0);
      en     = ($urandom_range(0, 9) != 0);
      inc_in = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
